// File: rtl/aes_pkg.sv
// Shared AES-128 widths, round-core timing defaults and the sequencer state encoding.
package aes_pkg;

   localparam int AES_BLK_W      = 128;
   localparam int AES_KEY_W      = 128;
   localparam int AES_ROUNDS_128 = 10;

   // Timing of the iterative round core this sequencer fronts
   localparam int AES_CORE_LAT      = 48;
   localparam int AES_LOAD_LAT      = 2;
   localparam int AES_CYC_PER_ROUND = 5;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_LOAD = 2'd1,
      ST_RUN  = 2'd2,
      ST_HOLD = 2'd3
   } aes_state_e;

endpackage

// File: rtl/aes_round_tracker.sv
// Elapsed-cycle counter and round index for the AES round core.
// Round index is derived from a phase counter that wraps every CYC_PER_ROUND cycles.
module aes_round_tracker
   import aes_pkg::*;
#(
   parameter int ROUNDS        = AES_ROUNDS_128,
   parameter int CORE_LAT      = AES_CORE_LAT,
   parameter int LOAD_LAT      = AES_LOAD_LAT,
   parameter int CYC_PER_ROUND = AES_CYC_PER_ROUND,
   parameter int CNT_W         = $clog2(AES_CORE_LAT + 1)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             i_start,
   input  logic             i_clear,
   input  logic             i_run,
   output logic [CNT_W-1:0] o_cnt,
   output logic [3:0]       o_round_idx,
   output logic             o_lat_hit
);

   localparam int PH_W = $clog2(CYC_PER_ROUND + 1);

   logic [CNT_W-1:0] r_cnt;
   logic [PH_W-1:0]  r_phase;
   logic [3:0]       r_round_idx;
   logic             w_cnt_at_lat;
   logic [CNT_W-1:0] w_cnt_nxt;

   assign w_cnt_at_lat = (r_cnt == CNT_W'(CORE_LAT));
   assign w_cnt_nxt    = w_cnt_at_lat ? r_cnt : r_cnt + 1'b1;

   // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_cnt       <= '0;
         r_phase     <= '0;
         r_round_idx <= '0;
      end else if (i_clear || i_start) begin
         r_cnt       <= '0;
         r_phase     <= '0;
         r_round_idx <= '0;
      end else if (i_run) begin
         r_cnt <= w_cnt_nxt;
         if (!w_cnt_at_lat && (w_cnt_nxt == CNT_W'(LOAD_LAT))) begin
            r_round_idx <= 4'd1;
            r_phase     <= '0;
         end else if (r_round_idx != 4'd0) begin
            if (r_phase == PH_W'(CYC_PER_ROUND - 1)) begin
               r_phase <= '0;
               if (r_round_idx != 4'(ROUNDS)) begin
                  r_round_idx <= r_round_idx + 4'd1;
               end
            end else begin
               r_phase <= r_phase + 1'b1;
            end
         end
      end
   end

   assign o_cnt       = r_cnt;
   assign o_round_idx = r_round_idx;
   assign o_lat_hit   = w_cnt_at_lat;

endmodule

// File: rtl/aes_round_seq.sv
// Sequencer in front of the iterative AES-128 round core: one block in flight at a time.
// Define AES_ROUND_SEQ_PERF_EN to add the blk_count / stall_cycles performance counters.
module aes_round_seq
   import aes_pkg::*;
#(
   parameter int ROUNDS        = AES_ROUNDS_128,
   parameter int CORE_LAT      = AES_CORE_LAT,
   parameter int LOAD_LAT      = AES_LOAD_LAT,
   parameter int CYC_PER_ROUND = AES_CYC_PER_ROUND
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 in_valid,
   output logic                 in_ready,
   input  logic [AES_KEY_W-1:0] in_key,
   input  logic [AES_BLK_W-1:0] in_plaintext,
   input  logic                 flush,
   output logic                 core_enable,
   output logic [AES_KEY_W-1:0] core_key,
   output logic [AES_BLK_W-1:0] core_plaintext,
   input  logic [AES_BLK_W-1:0] core_ciphertext,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic [AES_BLK_W-1:0] out_ciphertext,
   output logic                 busy,
   output logic [3:0]           round_idx
`ifdef AES_ROUND_SEQ_PERF_EN
   ,
   output logic [31:0]          blk_count,
   output logic [31:0]          stall_cycles
`endif
);

   localparam int CNT_W = $clog2(CORE_LAT + 1);

   localparam logic [1:0] S_IDLE = ST_IDLE;
   localparam logic [1:0] S_LOAD = ST_LOAD;
   localparam logic [1:0] S_RUN  = ST_RUN;
   localparam logic [1:0] S_HOLD = ST_HOLD;

   if (ROUNDS < 1 || ROUNDS > 15) begin : g_chk_rounds
      $error("aes_round_seq: ROUNDS must be in 1..15");
   end
   if (CORE_LAT <= LOAD_LAT) begin : g_chk_lat
      $error("aes_round_seq: CORE_LAT must exceed LOAD_LAT");
   end

   logic [1:0]           r_state;
   logic [1:0]           w_state_nxt;
   logic                 w_accept;
   logic                 w_done;
   logic                 w_run;
   logic                 w_lat_hit;
   logic [CNT_W-1:0]     w_cnt;
   logic [AES_KEY_W-1:0] r_core_key;
   logic [AES_BLK_W-1:0] r_core_plaintext;
   logic [AES_BLK_W-1:0] r_out_ciphertext;

   assign w_accept = (r_state == S_IDLE) && in_valid && !flush;
   assign w_done   = (r_state == S_HOLD) && out_ready;
   assign w_run    = (r_state == S_LOAD) || (r_state == S_RUN);

   // NOTE: next-state is defaulted first so no path through the block can infer a latch.
   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         S_IDLE:  if (w_accept) w_state_nxt = S_LOAD;
         S_LOAD:  w_state_nxt = S_RUN;
         S_RUN:   if (w_lat_hit) w_state_nxt = S_HOLD;
         S_HOLD:  if (out_ready) w_state_nxt = S_IDLE;
         default: w_state_nxt = S_IDLE;
      endcase
      if (flush) begin
         w_state_nxt = S_IDLE;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // NOTE: the wide datapath registers are reset because their zero value is architecturally visible.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_core_key       <= '0;
         r_core_plaintext <= '0;
         r_out_ciphertext <= '0;
      end else begin
         if (w_accept) begin
            r_core_key       <= in_key;
            r_core_plaintext <= in_plaintext;
         end
         if ((r_state == S_RUN) && w_lat_hit && !flush) begin
            r_out_ciphertext <= core_ciphertext;
         end
      end
   end

   aes_round_tracker #(
      .ROUNDS        (ROUNDS),
      .CORE_LAT      (CORE_LAT),
      .LOAD_LAT      (LOAD_LAT),
      .CYC_PER_ROUND (CYC_PER_ROUND),
      .CNT_W         (CNT_W)
   ) u_tracker (
      .clk         (clk),
      .rst         (rst),
      .i_start     (w_accept),
      .i_clear     (flush || w_done),
      .i_run       (w_run),
      .o_cnt       (w_cnt),
      .o_round_idx (round_idx),
      .o_lat_hit   (w_lat_hit)
   );

   // The core expects its enable on the cycle the elapsed count restarts at zero
   a_load_cnt_zero: assert property (@(posedge clk) disable iff (rst)
      (r_state == S_LOAD) |-> (w_cnt == '0));

   assign in_ready       = (r_state == S_IDLE);
   assign core_enable    = (r_state == S_LOAD);
   assign out_valid      = (r_state == S_HOLD);
   assign busy           = (r_state != S_IDLE);
   assign core_key       = r_core_key;
   assign core_plaintext = r_core_plaintext;
   assign out_ciphertext = r_out_ciphertext;

`ifdef AES_ROUND_SEQ_PERF_EN
   logic [31:0] r_blk_count;
   logic [31:0] r_stall_cycles;

   // Flush leaves both counters alone; only a real completion counts as a block
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_blk_count    <= '0;
         r_stall_cycles <= '0;
      end else begin
         if (w_done && !flush) begin
            r_blk_count <= r_blk_count + 32'd1;
         end
         if ((r_state == S_HOLD) && !out_ready) begin
            r_stall_cycles <= r_stall_cycles + 32'd1;
         end
      end
   end

   assign blk_count    = r_blk_count;
   assign stall_cycles = r_stall_cycles;
`endif

endmodule

// File: tb/tb_aes_round_seq.sv
// Directed bench for aes_round_seq with a stub core that returns key^plaintext at the fixed latency.
module tb_aes_round_seq;

   localparam int CORE_LAT = 48;
   localparam int LOAD_LAT = 2;
   localparam int CYC_PR   = 5;
   localparam int ROUNDS   = 10;

   localparam logic [127:0] KEY1 = 128'h000102030405060708090a0b0c0d0e0f;
   localparam logic [127:0] PT1  = 128'h00112233445566778899aabbccddeeff;
   localparam logic [127:0] CT1  = 128'h00102030405060708090a0b0c0d0e0f0;
   localparam logic [127:0] KEY2 = 128'h2b7e151628aed2a6abf7158809cf4f3c;
   localparam logic [127:0] PT2  = 128'h3243f6a8885a308d313198a2e0370734;
   localparam logic [127:0] CT2  = 128'h193de3bea0f4e22b9ac68d2ae9f84808;
   localparam logic [127:0] KEY3 = 128'hffffffffffffffffffffffffffffffff;
   localparam logic [127:0] PT3  = 128'h0123456789abcdef0123456789abcdef;
   localparam logic [127:0] CT3  = 128'hfedcba9876543210fedcba9876543210;
   localparam logic [127:0] KEY4 = 128'h55555555555555555555555555555555;
   localparam logic [127:0] PT4  = 128'haaaaaaaaaaaaaaaaaaaaaaaaaaaaaaaa;
   localparam logic [127:0] CT4  = 128'hffffffffffffffffffffffffffffffff;
   localparam logic [127:0] JUNK = 128'hdeadbeefdeadbeefdeadbeefdeadbeef;

   logic         clk = 1'b0;
   logic         rst;
   logic         in_valid;
   logic         in_ready;
   logic [127:0] in_key;
   logic [127:0] in_plaintext;
   logic         flush;
   logic         core_enable;
   logic [127:0] core_key;
   logic [127:0] core_plaintext;
   logic [127:0] core_ciphertext;
   logic         out_valid;
   logic         out_ready;
   logic [127:0] out_ciphertext;
   logic         busy;
   logic [3:0]   round_idx;
`ifdef AES_ROUND_SEQ_PERF_EN
   logic [31:0]  blk_count;
   logic [31:0]  stall_cycles;
`endif

   int n_checks = 0;
   int n_errors = 0;
   int stub_cnt = -1;

   aes_round_seq dut (
      .clk             (clk),
      .rst             (rst),
      .in_valid        (in_valid),
      .in_ready        (in_ready),
      .in_key          (in_key),
      .in_plaintext    (in_plaintext),
      .flush           (flush),
      .core_enable     (core_enable),
      .core_key        (core_key),
      .core_plaintext  (core_plaintext),
      .core_ciphertext (core_ciphertext),
      .out_valid       (out_valid),
      .out_ready       (out_ready),
      .out_ciphertext  (out_ciphertext),
      .busy            (busy),
`ifdef AES_ROUND_SEQ_PERF_EN
      .blk_count       (blk_count),
      .stall_cycles    (stall_cycles),
`endif
      .round_idx       (round_idx)
   );

   always #5 clk = ~clk;

   // Stub core: counts cycles since its enable, ciphertext is only meaningful at CORE_LAT
   always @(posedge clk or posedge rst) begin
      if (rst) stub_cnt <= -1;
      else if (core_enable) stub_cnt <= 1;
      else if (stub_cnt > 0 && stub_cnt < 1000) stub_cnt <= stub_cnt + 1;
   end
   assign core_ciphertext = (stub_cnt == CORE_LAT) ? (core_key ^ core_plaintext) : JUNK;

   task automatic check(input string tag, input logic [127:0] act, input logic [127:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", tag, act, exp);
      end
   endtask

   function automatic int exp_round(input int k);
      int r;
      if (k < LOAD_LAT) return 0;
      r = 1 + (k - LOAD_LAT) / CYC_PR;
      return (r > ROUNDS) ? ROUNDS : r;
   endfunction

   task automatic do_block(input string tag, input logic [127:0] key, input logic [127:0] pt,
                           input logic [127:0] exp_ct, input bit flush_in_hold);
      int lat;
      lat = 0;
      in_valid = 1'b1; in_key = key; in_plaintext = pt;
      check({tag, "_in_ready"}, in_ready, 1);
      @(negedge clk);
      in_valid = 1'b0;
      check({tag, "_enable"}, core_enable, 1);
      while (!out_valid && lat < 100) begin
         @(negedge clk);
         lat++;
      end
      check({tag, "_lat"}, lat, CORE_LAT + 1);
      check({tag, "_ct"}, out_ciphertext, exp_ct);
      check({tag, "_round_hold"}, round_idx, ROUNDS);
      out_ready = 1'b1;
      flush = flush_in_hold;
      @(negedge clk);
      out_ready = 1'b0;
      flush = 1'b0;
      check({tag, "_out_drop"}, out_valid, 0);
      check({tag, "_idle"}, busy, 0);
      check({tag, "_round_idle"}, round_idx, 0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      int first_en, second_en, n_out, seen;
      logic prev_en;

      rst = 1'b1; in_valid = 1'b0; in_key = '0; in_plaintext = '0;
      flush = 1'b0; out_ready = 1'b0;
      #3;
      check("rst_in_ready", in_ready, 1);
      check("rst_core_enable", core_enable, 0);
      check("rst_out_valid", out_valid, 0);
      check("rst_busy", busy, 0);
      check("rst_core_key", core_key, 0);
      check("rst_core_pt", core_plaintext, 0);
      check("rst_out_ct", out_ciphertext, 0);
      check("rst_round", round_idx, 0);
      repeat (2) @(negedge clk);
      rst = 1'b0;
      @(negedge clk);

      // Basic block with per-cycle round tracking, then 20 cycles of back-pressure
      in_valid = 1'b1; in_key = KEY1; in_plaintext = PT1;
      check("basic_in_ready", in_ready, 1);
      @(negedge clk);
      in_valid = 1'b0; in_key = '0; in_plaintext = '0;
      check("basic_enable", core_enable, 1);
      check("basic_core_key", core_key, KEY1);
      check("basic_core_pt", core_plaintext, PT1);
      check("basic_round_load", round_idx, 0);
      check("basic_busy_load", busy, 1);
      check("basic_in_ready_load", in_ready, 0);
      for (int k = 1; k <= CORE_LAT; k++) begin
         @(negedge clk);
         check($sformatf("basic_round_%0d", k), round_idx, exp_round(k));
         check($sformatf("basic_noout_%0d", k), out_valid, 0);
         check($sformatf("basic_noen_%0d", k), core_enable, 0);
      end
      @(negedge clk);
      check("basic_out_valid", out_valid, 1);
      check("basic_ct", out_ciphertext, CT1);
      check("basic_round_hold", round_idx, ROUNDS);
      check("basic_core_key_hold", core_key, KEY1);
      for (int i = 1; i < 20; i++) begin
         @(negedge clk);
         check($sformatf("bp_valid_%0d", i), out_valid, 1);
         check($sformatf("bp_ct_%0d", i), out_ciphertext, CT1);
         check($sformatf("bp_in_ready_%0d", i), in_ready, 0);
      end
      @(negedge clk);
      out_ready = 1'b1;
      check("bp_still_valid", out_valid, 1);
`ifdef AES_ROUND_SEQ_PERF_EN
      check("bp_stall_cycles", stall_cycles, 20);
      check("bp_blk_before", blk_count, 0);
`endif
      @(negedge clk);
      out_ready = 1'b0;
      check("bp_out_drop", out_valid, 0);
      check("bp_in_ready_back", in_ready, 1);
      check("bp_round_idle", round_idx, 0);
      check("bp_busy_idle", busy, 0);
`ifdef AES_ROUND_SEQ_PERF_EN
      check("bp_blk_after", blk_count, 1);
`endif

      // Back-to-back: in_valid held across two blocks, out_ready tied high
      out_ready = 1'b1;
      in_valid = 1'b1; in_key = KEY2; in_plaintext = PT2;
      first_en = -1; second_en = -1; n_out = 0; prev_en = 1'b0;
      for (int c = 0; c < 130; c++) begin
         @(negedge clk);
         if (core_enable) begin
            check("b2b_no_consec_en", prev_en, 0);
            if (first_en < 0) begin
               first_en = c; in_key = KEY3; in_plaintext = PT3;
            end else if (second_en < 0) begin
               second_en = c; in_valid = 1'b0;
            end
         end
         prev_en = core_enable;
         if (out_valid) begin
            check($sformatf("b2b_ct_%0d", n_out), out_ciphertext, (n_out == 0) ? CT2 : CT3);
            n_out++;
         end
      end
      check("b2b_en_gap", second_en - first_en, CORE_LAT + 3);
      check("b2b_blocks", n_out, 2);
      out_ready = 1'b0;
      in_valid = 1'b0;
`ifdef AES_ROUND_SEQ_PERF_EN
      check("b2b_blk_count", blk_count, 3);
`endif

      // Flush at cnt=20
      @(negedge clk);
      in_valid = 1'b1; in_key = KEY1; in_plaintext = PT1;
      @(negedge clk);
      in_valid = 1'b0;
      check("flush_enable", core_enable, 1);
      repeat (20) @(negedge clk);
      check("flush_round_at_20", round_idx, 4);
      flush = 1'b1;
      @(negedge clk);
      flush = 1'b0;
      check("flush_idle", busy, 0);
      check("flush_in_ready", in_ready, 1);
      check("flush_round", round_idx, 0);
      check("flush_no_enable", core_enable, 0);
      seen = 0;
      repeat (60) begin
         @(negedge clk);
         if (out_valid) seen++;
      end
      check("flush_no_out", seen, 0);

      // Flush wins over a block offered in IDLE
      in_valid = 1'b1; in_key = KEY2; in_plaintext = PT2; flush = 1'b1;
      @(negedge clk);
      in_valid = 1'b0; flush = 1'b0;
      check("flush_idle_no_accept", core_enable, 0);
      check("flush_idle_not_busy", busy, 0);

      do_block("after_flush", KEY3, PT3, CT3, 1'b0);
`ifdef AES_ROUND_SEQ_PERF_EN
      check("after_flush_blk", blk_count, 4);
`endif
      do_block("flush_hold", KEY2, PT2, CT2, 1'b1);
`ifdef AES_ROUND_SEQ_PERF_EN
      check("flush_hold_blk", blk_count, 4);
      check("flush_hold_stall", stall_cycles, 20);
`endif

      // Asynchronous reset mid-RUN, between clock edges
      in_valid = 1'b1; in_key = KEY1; in_plaintext = PT1;
      @(negedge clk);
      in_valid = 1'b0;
      repeat (10) @(negedge clk);
      check("pre_rst_busy", busy, 1);
      #2 rst = 1'b1;
      #1;
      check("arst_busy", busy, 0);
      check("arst_in_ready", in_ready, 1);
      check("arst_core_enable", core_enable, 0);
      check("arst_out_valid", out_valid, 0);
      check("arst_round", round_idx, 0);
      check("arst_core_key", core_key, 0);
      check("arst_core_pt", core_plaintext, 0);
      check("arst_out_ct", out_ciphertext, 0);
`ifdef AES_ROUND_SEQ_PERF_EN
      check("arst_blk", blk_count, 0);
      check("arst_stall", stall_cycles, 0);
`endif
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      do_block("after_rst", KEY4, PT4, CT4, 1'b0);
`ifdef AES_ROUND_SEQ_PERF_EN
      check("after_rst_blk", blk_count, 1);
`endif

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/aes_round_seq.md
Name: aes_round_seq

Overview:
- Sequencer in front of the iterative AES-128 round core.
- Accepts {key, plaintext} blocks over a valid/ready handshake and fires the core's one-cycle enable.
- Tracks elapsed core cycles and the current round index for key-schedule observers, captures the core ciphertext at the fixed latency, and holds it on a valid/ready output until it is consumed.
- Processes one block at a time; no overlap.

Parameters:
- ROUNDS, 10: AES rounds; round_idx saturates here.
- CORE_LAT, 48: cycles from the core_enable cycle (cnt=0) to the cycle where core_ciphertext is valid.
- LOAD_LAT, 2: cycles from the core_enable cycle until round 1 starts.
- CYC_PER_ROUND, 5: core cycles per round (register depth of the round loop).

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous, active-high reset
- in_valid  in  1  upstream block valid
- in_ready  out  1  block accepted when in_valid & in_ready
- in_key  in  128  cipher key
- in_plaintext  in  128  plaintext
- flush  in  1  synchronous abort; return to IDLE
- core_enable  out  1  one-cycle pulse to the core
- core_key  out  128  registered key to the core
- core_plaintext  out  128  registered plaintext to the core
- core_ciphertext  in  128  core output
- out_valid  out  1  ciphertext valid
- out_ready  in  1  downstream accept
- out_ciphertext  out  128  captured ciphertext
- busy  out  1  high in any state other than IDLE
- round_idx  out  4  0 during load; 1..ROUNDS while running

Behaviour:
- Reset (async assert; deassertion sampled on clk):
  - state=IDLE, in_ready=1.
  - core_enable, out_valid, busy = 0.
  - core_key, core_plaintext, out_ciphertext = 0.
  - cnt=0, phase=0, round_idx=0.
- IDLE:
  - in_ready=1.
  - On in_valid: latch in_key/in_plaintext into core_key/core_plaintext, go to LOAD.
- LOAD (1 cycle):
  - core_enable=1, cnt=0, busy=1, in_ready=0.
  - Next state is RUN.
  - core_key/core_plaintext stay stable from LOAD until the state returns to IDLE.
- RUN:
  - cnt increments by 1 each cycle.
  - When cnt reaches LOAD_LAT: round_idx becomes 1 and phase becomes 0.
  - After that, phase counts 0..CYC_PER_ROUND-1. On each wrap, round_idx increments, saturating at ROUNDS.
  - Implement with the phase counter; no divider.
  - On the cycle where cnt==CORE_LAT: register core_ciphertext into out_ciphertext and go to HOLD.
- HOLD:
  - out_valid=1, busy=1.
  - out_ciphertext is stable while out_valid & !out_ready.
  - On out_ready: out_valid drops next cycle, go to IDLE, round_idx returns to 0.
- Latency:
  - Input handshake at cycle T gives core_enable at T+1.
  - out_valid first rises at T+CORE_LAT+2.
  - With out_ready tied high, the next in_ready rises at T+CORE_LAT+3.
- Throughput: one block per CORE_LAT+3 cycles.
- flush:
  - In any state: next state is IDLE; out_valid, core_enable, cnt, phase, round_idx all clear.
  - Flush wins over a simultaneous in_valid or out_ready. A block offered in IDLE in the same cycle as flush is not accepted.
- core_enable is never asserted outside LOAD and never for two consecutive cycles.
- Width rules:
  - cnt width is $clog2(CORE_LAT+1).
  - round_idx is 4 bits; ROUNDS ≤ 15 is enforced by an elaboration check.
  - CORE_LAT > LOAD_LAT is enforced by an elaboration check.
- Illegal state encodings recover to IDLE.

Optional Feature:
- Macro: AES_ROUND_SEQ_PERF_EN.
- When defined:
  - Adds output blk_count (32) and output stall_cycles (32).
  - blk_count increments on each HOLD→IDLE completion and wraps modulo 2^32.
  - stall_cycles increments each HOLD cycle with out_ready=0 and wraps modulo 2^32.
  - Both reset to 0 on rst only; flush does not clear them.
- When undefined: neither port nor the counter logic exists.

Decomposition:
- Shared package aes_pkg holds:
  - state enum (IDLE, LOAD, RUN, HOLD);
  - AES_BLK_W=128, AES_KEY_W=128, AES_ROUNDS_128=10;
  - the default CORE_LAT, LOAD_LAT and CYC_PER_ROUND constants for the round core.
- One natural sub-module, aes_round_tracker: holds cnt/phase/round_idx. It takes a start pulse and clear, and outputs cnt, round_idx and lat_hit.

Test Plan:
- Basic: key=000102..0f, pt=00112233..ff; stub core returns pt^key at cnt==CORE_LAT → out_ciphertext=00102030405060708090a0b0c0d0e0f0, with out_valid at T+50 (defaults).
- Round tracking (defaults): round_idx=0 for cnt 0–1; =1 at cnt=2; =2 at cnt=7; =10 at cnt=47; holds 10 through HOLD; returns to 0 in IDLE.
- Back-pressure: out_ready low for 20 cycles → out_ciphertext stable, in_ready=0 throughout; perf build gives stall_cycles=20, then blk_count=1 after accept.
- Back-to-back: in_valid held with two blocks, out_ready=1 → second core_enable exactly CORE_LAT+3 cycles after the first; never two consecutive core_enable pulses.
- Flush at cnt=20 → IDLE next cycle, no out_valid; the following block completes normally. Flush together with out_ready in HOLD → IDLE, blk_count unchanged.
- Async rst asserted mid-RUN between clock edges → all outputs zero immediately; after release, in_ready=1 and a new block is accepted.
